// File: rtl/ft2_cmd_parser.sv
// FT2 host command parser: 5-byte frames (SYNC CMD ADDR DATA CHK) -> register strobes + response.
// Optional saturating error counter enabled by defining FT2_CMD_ERR_CNT_EN.
module ft2_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rd_en,
    input  logic [7:0] read_data,
    input  logic       data_ready,
    output logic       wr_en,
    output logic [7:0] write_data,
    input  logic       data_sent,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_count
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StHunt, StGetCmd, StGetAddr, StGetData, StGetChk, StExec, StRdWait, StTx
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, chk_q, chk_d;
    logic            rd_en_q, rd_en_d;
    logic            reg_wr_en_q, reg_wr_en_d, reg_rd_en_q, reg_rd_en_d;
    logic [7:0]      reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic [3:0][7:0] resp_q, resp_d;
    logic            len4_q, len4_d;
    logic [1:0]      idx_q, idx_d;
    logic            rd_phase_q, rd_phase_d;
    logic            err_event;
    logic            frame_ok;

    assign frame_ok = ((cmd_q ^ addr_q ^ data_q) == chk_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        reg_wr_en_d = 1'b0;
        reg_rd_en_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        resp_d      = resp_q;
        len4_d      = len4_q;
        idx_d       = idx_q;
        rd_phase_d  = rd_phase_q;
        err_event   = 1'b0;
        unique case (state_q)
            StHunt: begin
                timer_d = '0;
                if (data_ready && read_data == SYNC_BYTE) state_d = StGetCmd;
            end
            StGetCmd, StGetAddr, StGetData, StGetChk: begin
                if (data_ready) begin
                    timer_d = '0;
                    unique case (state_q)
                        StGetCmd:  begin cmd_d  = read_data; state_d = StGetAddr; end
                        StGetAddr: begin addr_d = read_data; state_d = StGetData; end
                        StGetData: begin data_d = read_data; state_d = StGetChk;  end
                        default:   begin chk_d  = read_data; state_d = StExec;    end
                    endcase
                end else if (timer_q == TimerLast) begin
                    // Inter-byte stall: drop the partial frame silently.
                    timer_d   = '0;
                    state_d   = StHunt;
                    err_event = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StExec: begin
                idx_d = 2'd0;
                if (frame_ok && cmd_q == 8'h01) begin
                    reg_wr_en_d = 1'b1;
                    reg_addr_d  = addr_q;
                    reg_wdata_d = data_q;
                    resp_d      = {16'h0000, 8'h06, SYNC_BYTE};
                    len4_d      = 1'b0;
                    state_d     = StTx;
                end else if (frame_ok && cmd_q == 8'h02) begin
                    reg_rd_en_d = 1'b1;
                    reg_addr_d  = addr_q;
                    rd_phase_d  = 1'b0;
                    state_d     = StRdWait;
                end else begin
                    resp_d    = {16'h0000, 8'h15, SYNC_BYTE};
                    len4_d    = 1'b0;
                    err_event = 1'b1;
                    state_d   = StTx;
                end
            end
            StRdWait: begin
                // First cycle is the strobe itself; read data lands on the next one.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    resp_d  = {addr_q ^ reg_rdata, reg_rdata, addr_q, SYNC_BYTE};
                    len4_d  = 1'b1;
                    state_d = StTx;
                end
            end
            StTx: begin
                if (data_sent) begin
                    if (idx_q == (len4_q ? 2'd3 : 2'd1)) begin
                        idx_d   = 2'd0;
                        state_d = StHunt;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StHunt;
        endcase
        rd_en_d = (state_d inside {StHunt, StGetCmd, StGetAddr, StGetData, StGetChk});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            timer_q     <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            rd_en_q     <= 1'b0;
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            resp_q      <= '0;
            len4_q      <= 1'b0;
            idx_q       <= 2'd0;
            rd_phase_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            rd_en_q     <= rd_en_d;
            reg_wr_en_q <= reg_wr_en_d;
            reg_rd_en_q <= reg_rd_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            resp_q      <= resp_d;
            len4_q      <= len4_d;
            idx_q       <= idx_d;
            rd_phase_q  <= rd_phase_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign wr_en      = (state_q == StTx);
    assign write_data = wr_en ? resp_q[idx_q] : 8'h00;
    assign busy       = (state_q inside {StExec, StRdWait, StTx});
    assign reg_wr_en  = reg_wr_en_q;
    assign reg_rd_en  = reg_rd_en_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;

`ifdef FT2_CMD_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (err_event && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
    assign err_count        = 8'h00;
`endif

endmodule
